// File: rtl/eyeriss_pkg.sv
// Shared types and helpers for the Eyeriss PE controller and datapath.
// Holds the mode encoding, the default operand width and saturating add.
package eyeriss_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_DATA = 2'd1,
    MODE_MULT = 2'd2,
    MODE_ACCU = 2'd3
  } mode_e;

  localparam int DEF_DATA_W = 16;
  localparam int IDX_W      = 4;

  // Adds in 64 bits, then clamps to a w-bit signed range (w <= 31).
  function automatic logic signed [63:0] sat_add(
    input  logic signed [63:0] a,
    input  logic signed [63:0] b,
    input  int                 w,
    output logic               ovf
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s   = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    ovf = 1'b0;
    if (s > hi) begin
      s   = hi;
      ovf = 1'b1;
    end else if (s < lo) begin
      s   = lo;
      ovf = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/eyeriss_pe_spad.sv
// Register-file scratchpad: one write port, a clear port that wins on
// the same address, and NRD async read ports; out-of-range reads give 0.
module eyeriss_pe_spad
  import eyeriss_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  parameter int NRD   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [IDX_W-1:0]          waddr,
  input  logic [W-1:0]              wdata,
  input  logic                      clr,
  input  logic [IDX_W-1:0]          caddr,
  input  logic [NRD-1:0][IDX_W-1:0] raddr,
  output logic [NRD-1:0][W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr && caddr == IDX_W'(i)) begin
          mem[i] <= '0;
        end else if (we && waddr == IDX_W'(i)) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (raddr[p] == IDX_W'(i)) rdata[p] = mem[i];
      end
    end
  end

endmodule

// File: rtl/eyeriss_pe_datapath.sv
// Eyeriss PE datapath: operand/psum scratchpads, two-stage MAC and
// psum drain with neighbour add, all saturating to DATA_W.
module eyeriss_pe_datapath
  import eyeriss_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIL_DEPTH  = 16,
  parameter int MAP_DEPTH  = 16,
  parameter int PSUM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_i,
  input  logic              fil_en_i,
  input  logic              map_en_i,
  input  logic              psum_en_i,
  input  logic              regs_en_i,
  input  logic              rst_accm_i,
  input  logic              read_next_p_i,
  input  logic              write_next_p_i,
  input  logic [3:0]        filter_iter_i,
  input  logic [3:0]        map_iter_i,
  input  logic [3:0]        psum_iter_i,
  input  logic [3:0]        mult_bit_select_i,
  input  logic [DATA_W-1:0] fil_data_i,
  input  logic [DATA_W-1:0] map_data_i,
  input  logic [DATA_W-1:0] psum_in_i,
  output logic              fil_pop_o,
  output logic              map_pop_o,
  output logic [DATA_W-1:0] psum_out_o,
  output logic              psum_valid_o,
  output logic              overflow_o
);

  localparam int PW = 2 * DATA_W;

  mode_e mode;
  mode_e mode_q;
  logic  in_data, in_mult, in_accu;
  logic  fire_s1, fire_rd, psum_clr;

  logic [DATA_W-1:0]          fil_rd, map_rd;
  logic [1:0][DATA_W-1:0]     psum_rd;

  logic                   s1_valid;
  logic signed [PW-1:0]   s1_prod;
  logic [3:0]             s1_addr;
  logic [3:0]             s1_shift;

  logic signed [PW-1:0]   prod_sh;
  logic signed [63:0]     s2_a, s2_b, dr_a, dr_b;
  logic [DATA_W-1:0]      s2_sum, dr_sum;
  logic                   s2_ovf, dr_ovf;

  assign mode    = mode_e'(mode_i);
  assign in_data = (mode == MODE_DATA);
  assign in_mult = (mode == MODE_MULT);
  assign in_accu = (mode == MODE_ACCU);

  assign fil_pop_o = in_data & fil_en_i;
  assign map_pop_o = in_data & map_en_i;
  assign fire_s1   = in_mult & regs_en_i;
  assign fire_rd   = in_accu & read_next_p_i;
  assign psum_clr  = (in_data & psum_en_i & ~rst_accm_i)
                   | (in_accu & write_next_p_i);

  eyeriss_pe_spad #(.DEPTH(FIL_DEPTH), .W(DATA_W), .NRD(1)) u_fil (
    .clk   (clk),
    .rst   (rst),
    .we    (fil_pop_o),
    .waddr (filter_iter_i),
    .wdata (fil_data_i),
    .clr   (1'b0),
    .caddr (4'd0),
    .raddr (filter_iter_i),
    .rdata (fil_rd)
  );

  eyeriss_pe_spad #(.DEPTH(MAP_DEPTH), .W(DATA_W), .NRD(1)) u_map (
    .clk   (clk),
    .rst   (rst),
    .we    (map_pop_o),
    .waddr (map_iter_i),
    .wdata (map_data_i),
    .clr   (1'b0),
    .caddr (4'd0),
    .raddr (map_iter_i),
    .rdata (map_rd)
  );

  // Port 0 feeds stage 2, port 1 feeds the drain path.
  eyeriss_pe_spad #(.DEPTH(PSUM_DEPTH), .W(DATA_W), .NRD(2)) u_psum (
    .clk   (clk),
    .rst   (rst),
    .we    (s1_valid),
    .waddr (s1_addr),
    .wdata (s2_sum),
    .clr   (psum_clr),
    .caddr (psum_iter_i),
    .raddr ({psum_iter_i, s1_addr}),
    .rdata (psum_rd)
  );

  // Stage 2 reads and writes psum in one cycle, so back-to-back
  // updates to one address see the previous result without a bypass mux.
  assign prod_sh = s1_prod >>> s1_shift;
  assign s2_a = {{(64-DATA_W){psum_rd[0][DATA_W-1]}}, psum_rd[0]};
  assign s2_b = {{(64-PW){prod_sh[PW-1]}}, prod_sh};
  assign dr_a = {{(64-DATA_W){psum_rd[1][DATA_W-1]}}, psum_rd[1]};
  assign dr_b = {{(64-DATA_W){psum_in_i[DATA_W-1]}}, psum_in_i};

  always_comb begin
    s2_ovf = 1'b0;
    dr_ovf = 1'b0;
    s2_sum = DATA_W'(sat_add(s2_a, s2_b, DATA_W, s2_ovf));
    dr_sum = DATA_W'(sat_add(dr_a, dr_b, DATA_W, dr_ovf));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_IDLE;
      s1_valid     <= 1'b0;
      s1_prod      <= '0;
      s1_addr      <= '0;
      s1_shift     <= '0;
      psum_out_o   <= '0;
      psum_valid_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      mode_q       <= mode;
      s1_valid     <= fire_s1;
      psum_valid_o <= fire_rd;
      if (fire_s1) begin
        s1_prod  <= $signed(fil_rd) * $signed(map_rd);
        s1_addr  <= psum_iter_i;
        s1_shift <= mult_bit_select_i;
      end
      if (fire_rd) psum_out_o <= dr_sum;
      if ((s1_valid && s2_ovf) || (fire_rd && dr_ovf)) begin
        overflow_o <= 1'b1;
      end else if (mode_q == MODE_IDLE && in_data) begin
        overflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eyeriss_pe_datapath.sv
// Scoreboard bench for eyeriss_pe_datapath: drains push expected psums,
// a negedge monitor pops and compares on every psum_valid_o pulse.
module tb_eyeriss_pe_datapath;
  import eyeriss_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  mode_i;
  logic        fil_en_i, map_en_i, psum_en_i, regs_en_i;
  logic        rst_accm_i, read_next_p_i, write_next_p_i;
  logic [3:0]  filter_iter_i, map_iter_i, psum_iter_i;
  logic [3:0]  mult_bit_select_i;
  logic [15:0] fil_data_i, map_data_i, psum_in_i;
  logic        fil_pop_o, map_pop_o;
  logic [15:0] psum_out_o;
  logic        psum_valid_o, overflow_o;

  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;
  int          n_vec = 0;
  int          n_err = 0;

  eyeriss_pe_datapath #(
    .DATA_W(16), .FIL_DEPTH(8), .MAP_DEPTH(16), .PSUM_DEPTH(16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .mode_i            (mode_i),
    .fil_en_i          (fil_en_i),
    .map_en_i          (map_en_i),
    .psum_en_i         (psum_en_i),
    .regs_en_i         (regs_en_i),
    .rst_accm_i        (rst_accm_i),
    .read_next_p_i     (read_next_p_i),
    .write_next_p_i    (write_next_p_i),
    .filter_iter_i     (filter_iter_i),
    .map_iter_i        (map_iter_i),
    .psum_iter_i       (psum_iter_i),
    .mult_bit_select_i (mult_bit_select_i),
    .fil_data_i        (fil_data_i),
    .map_data_i        (map_data_i),
    .psum_in_i         (psum_in_i),
    .fil_pop_o         (fil_pop_o),
    .map_pop_o         (map_pop_o),
    .psum_out_o        (psum_out_o),
    .psum_valid_o      (psum_valid_o),
    .overflow_o        (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (psum_valid_o === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got psum_out=%h, no drain pending",
                 psum_out_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (psum_out_o !== mon_exp) begin
          n_err++;
          $display("FAIL drain: got psum_out=%h want %h", psum_out_o, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    mode_i = MODE_IDLE;
    {fil_en_i, map_en_i, psum_en_i, regs_en_i} = '0;
    {rst_accm_i, read_next_p_i, write_next_p_i} = '0;
    {filter_iter_i, map_iter_i, psum_iter_i, mult_bit_select_i} = '0;
    {fil_data_i, map_data_i, psum_in_i} = '0;
  endtask

  task automatic idle();
    quiet();
    step();
  endtask

  task automatic load(input logic [3:0] idx, input logic [15:0] f,
                      input logic [15:0] m);
    quiet();
    mode_i = MODE_DATA;
    fil_en_i = 1'b1;
    map_en_i = 1'b1;
    filter_iter_i = idx;
    map_iter_i = idx;
    fil_data_i = f;
    map_data_i = m;
    #1;
    chk("fil_pop", {15'd0, fil_pop_o}, 16'd1);
    chk("map_pop", {15'd0, map_pop_o}, 16'd1);
    step();
  endtask

  task automatic clr(input logic [3:0] idx);
    quiet();
    mode_i = MODE_DATA;
    psum_en_i = 1'b1;
    psum_iter_i = idx;
    step();
  endtask

  task automatic mult(input logic [3:0] fi, input logic [3:0] mi,
                      input logic [3:0] pi, input logic [3:0] sh);
    quiet();
    mode_i = MODE_MULT;
    regs_en_i = 1'b1;
    rst_accm_i = 1'b1;
    filter_iter_i = fi;
    map_iter_i = mi;
    psum_iter_i = pi;
    mult_bit_select_i = sh;
    step();
  endtask

  task automatic drain(input logic [3:0] idx, input logic [15:0] pin,
                       input logic [15:0] exp, input logic wclr);
    quiet();
    mode_i = MODE_ACCU;
    read_next_p_i = 1'b1;
    write_next_p_i = wclr;
    psum_iter_i = idx;
    psum_in_i = pin;
    exp_q.push_back(exp);
    step();
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    step();
    step();
    chk("rst_psum_out", psum_out_o, 16'h0);
    chk("rst_valid", {15'd0, psum_valid_o}, 16'd0);
    chk("rst_overflow", {15'd0, overflow_o}, 16'd0);
    chk("rst_fil_pop", {15'd0, fil_pop_o}, 16'd0);
    chk("rst_map_pop", {15'd0, map_pop_o}, 16'd0);
    rst = 1'b0;
    drain(4'd5, 16'h0, 16'h0, 1'b0);

    // 1*4 + 2*5 + 3*6 = 32, drained with neighbour 8 -> 40
    load(4'd0, 16'd1, 16'd4);
    load(4'd1, 16'd2, 16'd5);
    load(4'd2, 16'd3, 16'd6);
    clr(4'd0);
    mult(4'd0, 4'd0, 4'd0, 4'd0);
    mult(4'd1, 4'd1, 4'd0, 4'd0);
    mult(4'd2, 4'd2, 4'd0, 4'd0);
    idle();
    drain(4'd0, 16'd8, 16'd40, 1'b0);

    // three full-rate 0x100 products into psum[3]
    load(4'd3, 16'h0010, 16'h0010);
    clr(4'd3);
    mult(4'd3, 4'd3, 4'd3, 4'd0);
    mult(4'd3, 4'd3, 4'd3, 4'd0);
    mult(4'd3, 4'd3, 4'd3, 4'd0);
    idle();
    drain(4'd3, 16'h0, 16'h0300, 1'b0);

    // saturation and sticky overflow
    idle();
    load(4'd4, 16'h7FFF, 16'h7FFF);
    clr(4'd4);
    mult(4'd4, 4'd4, 4'd4, 4'd0);
    idle();
    chk("ovf_set", {15'd0, overflow_o}, 16'd1);
    drain(4'd4, 16'h0, 16'h7FFF, 1'b0);
    chk("ovf_sticky", {15'd0, overflow_o}, 16'd1);
    idle();
    clr(4'd5);
    chk("ovf_clr_on_data", {15'd0, overflow_o}, 16'd0);
    mult(4'd4, 4'd4, 4'd5, 4'd15);
    idle();
    chk("ovf_shift15", {15'd0, overflow_o}, 16'd0);
    drain(4'd5, 16'h0, 16'h7FFE, 1'b0);
    load(4'd6, 16'h8000, 16'h0000);
    clr(4'd6);
    mult(4'd6, 4'd4, 4'd6, 4'd0);
    idle();
    chk("ovf_neg", {15'd0, overflow_o}, 16'd1);
    drain(4'd6, 16'h0, 16'h8000, 1'b0);

    // simultaneous read and clear returns the old value
    load(4'd7, 16'h0055, 16'h0001);
    clr(4'd2);
    mult(4'd7, 4'd7, 4'd2, 4'd0);
    idle();
    drain(4'd2, 16'h0, 16'h0055, 1'b1);
    drain(4'd2, 16'h0, 16'h0000, 1'b0);

    // reset right after a MAC issue
    drain(4'd0, 16'd8, 16'd40, 1'b0);
    mult(4'd1, 4'd1, 4'd1, 4'd0);
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_psum_out", psum_out_o, 16'h0);
    chk("midrst_valid", {15'd0, psum_valid_o}, 16'd0);
    chk("midrst_overflow", {15'd0, overflow_o}, 16'd0);
    idle();
    drain(4'd1, 16'h0, 16'h0, 1'b0);
    drain(4'd0, 16'h0, 16'h0, 1'b0);

    // filter index 12 is beyond FIL_DEPTH=8
    load(4'd12, 16'h1234, 16'h0002);
    clr(4'd8);
    mult(4'd12, 4'd12, 4'd8, 4'd0);
    idle();
    drain(4'd8, 16'd3, 16'd3, 1'b0);
    load(4'd3, 16'h0010, 16'h0010);
    clr(4'd8);
    mult(4'd3, 4'd3, 4'd8, 4'd0);
    idle();
    drain(4'd8, 16'h0, 16'h0100, 1'b0);

    idle();
    idle();
    idle();
    chk("pending_drains", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
